// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer: data width,
// opcodes and FSM state encoding.
package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // SLT always subtracts; ADD follows the command's subtract bit; logic ops never subtract.
    function automatic logic alu_sub_for(input logic [1:0] op, input logic sub);
        logic r;
        case (op)
            OP_SLT:  r = 1'b1;
            OP_ADD:  r = sub;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times how long the external ALU is given to settle.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to an external combinational ALU, waits a fixed
// settle time, captures the result and holds it until the consumer takes it.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_sub,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    output logic             alu_op0,
    output logic             alu_op1,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic [7:0]       cmd_count,
    output logic [1:0]       dbg_state
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready.
    // Holding either valid while its ready is low has no effect.

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t r_state;
    logic   w_accept;
    logic   w_zero;
    logic   w_dec;

    assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
    assign w_dec     = (r_state == ST_SETTLE) && !w_zero;
    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign dbg_state = r_state;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sub   <= 1'b0;
            alu_op0   <= 1'b0;
            alu_op1   <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= 2'b00;
            cmd_count <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_a   <= cmd_a;
                        alu_b   <= cmd_b;
                        alu_op0 <= cmd_op[1];
                        alu_op1 <= cmd_op[0];
                        alu_sub <= alu_sub_for(cmd_op, cmd_sub);
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // The opcode comes from the latched ALU controls; cmd_op may have moved on.
                    if (w_zero) begin
                        rsp_data <= alu_out;
                        rsp_op   <= {alu_op0, alu_op1};
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        cmd_count <= cmd_count + 8'd1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with an ideal combinational ALU attached.
module tb_alu_cmd_issuer;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_sub;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_sub;
    logic        alu_op0;
    logic        alu_op1;
    logic [15:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_op;
    logic [7:0]  cmd_count;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_count;

    alu_cmd_issuer #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sub   (cmd_sub),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sub   (alu_sub),
        .alu_op0   (alu_op0),
        .alu_op1   (alu_op1),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .cmd_count (cmd_count),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal ALU: SLT is only a true signed compare when the subtractor is selected.
    always_comb begin
        logic [15:0] sum;
        sum = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
        case ({alu_op0, alu_op1})
            2'b00:   alu_out = alu_a & alu_b;
            2'b01:   alu_out = alu_a | alu_b;
            2'b10:   alu_out = sum;
            default: alu_out = alu_sub ? {15'd0, ($signed(alu_a) < $signed(alu_b))} : {15'd0, sum[15]};
        endcase
    end

    // Reference: what the command asks for, straight from its meaning.
    function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic [1:0] op, input logic sub);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return sub ? 16'((int'(a) - int'(b)) & 32'hFFFF) : 16'((int'(a) + int'(b)) & 32'hFFFF);
            default: return (sa < sb) ? 16'd1 : 16'd0;
        endcase
    endfunction

    function automatic logic ref_sub(input logic [1:0] op, input logic sub);
        if (op == 2'd3) return 1'b1;
        if (op == 2'd2) return sub;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_op", rsp_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_ctl", {alu_sub, alu_op0, alu_op1}, 0);
        check("rst_cmd_count", cmd_count, 0);
    endtask

    // Driver: issue one command, watch it through settle, hold the response for
    // `hold` cycles with rsp_ready low (and a competing command offered), then retire it.
    task automatic do_cmd(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic sub,
                          input logic [15:0] exp_data, input int hold);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_sub = sub; cmd_valid = 1'b1;
        tick;
        check("acc_alu_a", alu_a, a);
        check("acc_alu_b", alu_b, b);
        check("acc_alu_op", {alu_op0, alu_op1}, op);
        check("acc_alu_sub", alu_sub, ref_sub(op, sub));
        check("acc_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_a = 16'($urandom);
        cmd_op = 2'($urandom);
        for (int i = 1; i < S; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            tick;
            check("settle_rsp_valid", rsp_valid, 0);
            check("settle_alu_a", alu_a, a);
        end
        rsp_ready = 1'($urandom_range(0, 1));
        tick;
        check("cap_rsp_valid", rsp_valid, 1);
        check("cap_rsp_data", rsp_data, exp_data);
        check("cap_rsp_op", rsp_op, op);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_a = 16'($urandom);
            tick;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, exp_data);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_alu_a", alu_a, a);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick;
        exp_count = exp_count + 8'd1;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_cmd_ready", cmd_ready, 1);
        check("done_cmd_count", cmd_count, exp_count);
        check("done_alu_a_held", alu_a, a);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        sub;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_count = 8'd0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_sub = 1'b0;
        cmd_a = 16'd0;
        cmd_b = 16'd0;
        rsp_ready = 1'b0;

        vecs[0] = '{16'd2,     16'd4,  2'b10, 1'b0, 16'd6};
        vecs[1] = '{16'd5,     16'd2,  2'b10, 1'b1, 16'd3};
        vecs[2] = '{16'd5,     16'd2,  2'b01, 1'b0, 16'd7};
        vecs[3] = '{16'd5,     16'd7,  2'b00, 1'b0, 16'd5};
        vecs[4] = '{16'd30,    16'd40, 2'b11, 1'b0, 16'd1};
        vecs[5] = '{16'd20,    16'd10, 2'b11, 1'b0, 16'd0};
        vecs[6] = '{16'hFFFF,  16'd1,  2'b10, 1'b0, 16'h0000};
        vecs[7] = '{16'd0,     16'd1,  2'b10, 1'b1, 16'hFFFF};
        vecs[8] = '{16'h8000,  16'd1,  2'b11, 1'b1, 16'd1};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors; the first is accepted on the first edge after reset release.
        for (int i = 0; i < 9; i++) begin
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sub, vecs[i].exp_data, (i == 0) ? 5 : i % 3);
        end

        // Reset in the middle of SETTLE discards the command.
        cmd_a = 16'd9; cmd_b = 16'd9; cmd_op = 2'b10; cmd_sub = 1'b0; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_count = 8'd0;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < S + 2; i++) begin
            tick;
            check("post_rst_rsp_valid", rsp_valid, 0);
            check("post_rst_cmd_ready", cmd_ready, 1);
        end

        // Reset while a response is waiting.
        do_cmd(16'd1, 16'd2, 2'b01, 1'b0, 16'd3, 0);
        cmd_a = 16'd4; cmd_b = 16'd4; cmd_op = 2'b00; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        repeat (S) tick;
        check("pre_rst_resp", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        exp_count = 8'd0;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Random commands against the reference; 256 of them wrap cmd_count back to 0.
        for (int n = 0; n < 256; n++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic [1:0]  op;
            logic        sub;
            a = 16'($urandom);
            b = 16'($urandom);
            op = 2'($urandom);
            sub = 1'($urandom);
            do_cmd(a, b, op, sub, ref_result(a, b, op, sub), int'($urandom_range(0, 2)));
        end
        check("wrap_cmd_count", cmd_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
